// File: rtl/systolic_pkg.sv
//============================================================================
// Module : systolic_pkg
// Brief  : Shared types, defaults and column-bus helpers for the systolic
//          array edge logic.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package systolic_pkg;

   localparam int c_DEFAULT_DATA_WIDTH = 16;
   localparam int c_DEFAULT_COLS       = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } state_e;

   typedef logic [c_DEFAULT_COLS-1:0][c_DEFAULT_DATA_WIDTH-1:0] row_t;

   function automatic logic [c_DEFAULT_COLS*c_DEFAULT_DATA_WIDTH-1:0] row_flatten(input row_t r);
      logic [c_DEFAULT_COLS*c_DEFAULT_DATA_WIDTH-1:0] f;
      f = '0;
      for (int c = 0; c < c_DEFAULT_COLS; c++)
         f[c*c_DEFAULT_DATA_WIDTH +: c_DEFAULT_DATA_WIDTH] = r[c];
      return f;
   endfunction

   function automatic row_t row_unflatten(input logic [c_DEFAULT_COLS*c_DEFAULT_DATA_WIDTH-1:0] f);
      row_t r;
      for (int c = 0; c < c_DEFAULT_COLS; c++)
         r[c] = f[c*c_DEFAULT_DATA_WIDTH +: c_DEFAULT_DATA_WIDTH];
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/psum_deskew_collector_if.sv
//============================================================================
// Module : psum_deskew_collector_if
// Brief  : Partial-sum input bus and result-row valid/ready output bus.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface psum_deskew_collector_if
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
   parameter int COLS       = c_DEFAULT_COLS
);
   logic [COLS*DATA_WIDTH-1:0] psum_in;
   logic [COLS-1:0]            psum_valid;
   logic                       almost_full;
   logic [COLS*DATA_WIDTH-1:0] out_data;
   logic                       out_valid;
   logic                       out_ready;
   logic                       out_last;

   modport slave (
      input  psum_in, psum_valid, out_ready,
      output almost_full, out_data, out_valid, out_last
   );

   modport master (
      output psum_in, psum_valid, out_ready,
      input  almost_full, out_data, out_valid, out_last
   );
endinterface

`default_nettype wire

// File: rtl/psum_row_fifo.sv
//============================================================================
// Module : psum_row_fifo
// Brief  : Synchronous FIFO of result rows plus a last flag; head is read
//          straight from storage flops.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module psum_row_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             i_push,
   input  logic [WIDTH-1:0]                 i_push_data,
   input  logic                             i_push_last,
   input  logic                             i_pop,
   output logic [WIDTH-1:0]                 o_rd_data,
   output logic                             o_rd_last,
   output logic                             o_full,
   output logic                             o_empty,
   output logic [$clog2(DEPTH+1)-1:0]       o_free
);
   localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW = $clog2(DEPTH+1);

   logic [WIDTH:0]    r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_count;
   logic              w_wr_en;
   logic              w_rd_en;

   assign o_full  = (r_count == c_CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_free  = c_CW'(DEPTH) - r_count;

   // When full, a simultaneous pop frees the slot being written this edge.
   assign w_wr_en = i_push && (!o_full || i_pop);
   assign w_rd_en = i_pop && !o_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_rd_en})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr][WIDTH-1:0];
   assign o_rd_last = r_mem[r_rd_ptr][WIDTH] && !o_empty;

endmodule

`default_nettype wire

// File: rtl/psum_deskew_collector.sv
//============================================================================
// Module : psum_deskew_collector
// Brief  : Deskews the bottom-edge partial-sum stream into aligned rows and
//          hands them out through a row FIFO. PSUM_COLLECT_RELU_EN clamps
//          negative column values to zero at the FIFO write side.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module psum_deskew_collector
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
   parameter int COLS       = c_DEFAULT_COLS,
   parameter int ROWS       = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   psum_deskew_collector_if.slave bus,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  skew_err
);
   localparam int c_RCW = $clog2(ROWS+1);
   localparam int c_FCW = $clog2(FIFO_DEPTH+1);

   logic [COLS*DATA_WIDTH-1:0] w_al_data;
   logic [COLS*DATA_WIDTH-1:0] w_wr_data;
   logic [COLS-1:0]            w_av;
   logic                       w_all, w_partial, w_push, w_last_push, w_pop, w_drop;
   logic                       w_full, w_empty, w_rd_last;
   logic [c_FCW-1:0]           w_free;
   state_e                     r_state, w_state_nxt;
   logic [c_RCW-1:0]           r_row_cnt, w_row_cnt_nxt;
   logic                       r_done, r_overflow, r_skew_err;

   // Column c lags column 0 by c cycles, so it needs COLS-1-c stages.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int c_DEPTH = COLS - 1 - c;
      if (c_DEPTH == 0) begin : g_pass
         assign w_al_data[c*DATA_WIDTH +: DATA_WIDTH] = bus.psum_in[c*DATA_WIDTH +: DATA_WIDTH];
         assign w_av[c] = bus.psum_valid[c];
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] r_data [c_DEPTH];
         logic [c_DEPTH-1:0]    r_vld;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < c_DEPTH; i++) r_data[i] <= '0;
               r_vld <= '0;
            end else begin
               r_data[0] <= bus.psum_in[c*DATA_WIDTH +: DATA_WIDTH];
               r_vld[0]  <= bus.psum_valid[c];
               for (int i = 1; i < c_DEPTH; i++) begin
                  r_data[i] <= r_data[i-1];
                  r_vld[i]  <= r_vld[i-1];
               end
            end
         end
         assign w_al_data[c*DATA_WIDTH +: DATA_WIDTH] = r_data[c_DEPTH-1];
         assign w_av[c] = r_vld[c_DEPTH-1];
      end
   end

`ifdef PSUM_COLLECT_RELU_EN
   for (genvar c = 0; c < COLS; c++) begin : g_relu
      assign w_wr_data[c*DATA_WIDTH +: DATA_WIDTH] = w_al_data[c*DATA_WIDTH + DATA_WIDTH - 1] ?
                                                     '0 : w_al_data[c*DATA_WIDTH +: DATA_WIDTH];
   end
`else
   assign w_wr_data = w_al_data;
`endif

   assign w_all       = &w_av;
   assign w_partial   = |w_av && !w_all;
   assign w_push      = (r_state == COLLECT) && w_all;
   assign w_last_push = w_push && (r_row_cnt == c_RCW'(ROWS-1));
   assign w_pop       = !w_empty && bus.out_ready;
   assign w_drop      = w_push && w_full && !w_pop;

   psum_row_fifo #(
      .WIDTH (COLS*DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_wr_data),
      .i_push_last (w_last_push),
      .i_pop       (w_pop),
      .o_rd_data   (bus.out_data),
      .o_rd_last   (w_rd_last),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_free      (w_free)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_row_cnt_nxt = r_row_cnt;
      case (r_state)
         IDLE: if (start) begin
            w_state_nxt   = COLLECT;
            w_row_cnt_nxt = '0;
         end
         COLLECT: if (w_push) begin
            // Dropped rows still count so the tile always terminates.
            w_row_cnt_nxt = r_row_cnt + 1'b1;
            if (w_last_push) w_state_nxt = DRAIN;
         end
         DRAIN: if (w_pop && w_rd_last) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_row_cnt  <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_skew_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_row_cnt <= w_row_cnt_nxt;
         r_done    <= (r_state == DRAIN) && w_pop && w_rd_last;
         if (r_state == IDLE && start) begin
            r_overflow <= 1'b0;
            r_skew_err <= 1'b0;
         end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (r_state != IDLE && w_partial) r_skew_err <= 1'b1;
         end
      end
   end

   assign bus.out_valid   = !w_empty;
   assign bus.out_last    = w_rd_last;
   assign bus.almost_full = (32'(w_free) < COLS);
   assign busy            = (r_state != IDLE);
   assign done            = r_done;
   assign overflow        = r_overflow;
   assign skew_err        = r_skew_err;

endmodule

`default_nettype wire

// File: doc/psum_deskew_collector.md
# psum_deskew_collector

- Sits at the bottom edge of the weight-stationary systolic array and is the reader of its partial-sum stream.
- Takes the per-column `psum_out` values, which leave the array diagonally skewed (column c is c cycles later than column 0), and removes the skew.
- Buffers each aligned result row in a small FIFO and hands rows to downstream logic over a valid/ready handshake, with tile framing and error flags.

## Interface
- `DATA_WIDTH`, 16: width of each partial sum; matches PE width.
- `COLS`, 4: array columns, i.e. partial sums per result row.
- `ROWS`, 4: result rows per tile (activation vectors streamed through).
- `FIFO_DEPTH`, 4: row FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous and active-low; asserted (0) forces all state to reset values immediately.
- `start`  in  1  one-cycle pulse opening a tile; honoured only in IDLE.
- `psum_in`  in  COLS*DATA_WIDTH  bottom-row `psum_out` values; column c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- `psum_valid`  in  COLS  per-column valid; bit c qualifies column c this cycle.
- `almost_full`  out  1  free FIFO entries < COLS; upstream feeder must stop launching vectors.
- `out_data`  out  COLS*DATA_WIDTH  aligned result row, same column packing as `psum_in`.
- `out_valid`  out  1  `out_data` holds a row.
- `out_ready`  in  1  downstream accepts the row this cycle.
- `out_last`  out  1  qualifies `out_data` as row ROWS-1 of the tile.
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse when the tile's last row is popped.
- `overflow`  out  1  sticky: an aligned row was dropped because the FIFO was full.
- `skew_err`  out  1  sticky: aligned valids were partially set.

## Operation
- **Deskew:**
  - Column c passes through a delay line of COLS-1-c stages; column COLS-1 is undelayed. Data and valid travel together.
  - Delay lines shift every cycle in every state; they are never gated.
  - After the delay lines, all columns of vector m are aligned.
- **Aligned-valid vector `av`:**
  - All bits 1 in COLLECT: push the aligned row into the FIFO.
  - Some but not all bits 1, in any non-IDLE state: set `skew_err`; no push.
  - All bits 1 outside COLLECT: ignored.
- **FSM:**
  - IDLE → COLLECT on `start`. The row counter and both sticky flags clear on that edge.
  - COLLECT: each push increments the row counter (0..ROWS-1). When push number ROWS is accepted → DRAIN.
  - A row dropped on overflow still counts, so a tile always terminates.
  - DRAIN → IDLE on the edge where the row flagged last is popped. `done` is high for the cycle following that edge.
- **FIFO:**
  - Stores the row plus a last bit; the last bit is set on push number ROWS.
  - Pop happens when `out_valid && out_ready`.
  - Push and pop in the same cycle is always legal, including when full. A push into a full FIFO with a simultaneous pop succeeds.
  - A push into a full FIFO with no pop is dropped and sets `overflow`.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- **Data:** no arithmetic; values pass bit-exact (except under the macro below).
- **Ignored inputs:** `start` outside IDLE.
- **Reset values:**
  - `out_data` 0; `out_valid`, `out_last`, `busy`, `done`, `overflow`, `skew_err`, `almost_full` 0.
  - FSM IDLE, FIFO empty, delay lines cleared.
- **Reset mid-tile:** abandons the tile; all FIFO contents are discarded.

## Timing
- Column COLS-1 of vector m valid at `psum_in` in cycle t → row pushed at end of cycle t.
- If the FIFO was empty, `out_valid` rises in cycle t+1 (one cycle of latency from the last column).
- Column 0 of the same vector arrived in cycle t-(COLS-1).
- `out_valid`, `out_data` and `out_last` are registered FIFO-head outputs. They hold stable while `out_valid && !out_ready`.
- Throughput: one row per cycle sustained with `out_ready` held high.
- `almost_full` is combinational from the FIFO occupancy, recomputed each cycle.

## Configuration
- Macro `PSUM_COLLECT_RELU_EN`.
- **Defined:** each column value is treated as signed two's complement at the FIFO write side. Any value with MSB 1 is replaced by 0 before storage; latency is unchanged.
- **Undefined:** values are stored unmodified.

## Structure
- **Shared package `systolic_pkg`:**
  - Default DATA_WIDTH and COLS.
  - FSM state enum (IDLE, COLLECT, DRAIN).
  - Row typedef (COLS-wide array of DATA_WIDTH words).
  - Flatten/unflatten helper functions for the packed column bus.
- **Sub-module `psum_row_fifo`:**
  - Synchronous FIFO of row+last entries.
  - Outputs full, empty and free count.
  - Same `clk`/`reset` convention.

## Test plan
Unless stated otherwise, parameters are COLS=4, ROWS=4, FIFO_DEPTH=4.
1. **Clean tile:** `start`, then 4 vectors skewed correctly; column c of vector m = 16·m + c, `out_ready`=1 → rows {0,1,2,3}, {16..19}, {32..35}, {48..51} in order. `out_last` only on the 4th row; `done` pulses once; FSM returns to IDLE.
2. **Backpressure:** same stimulus with `out_ready`=0 until the FIFO holds 4 rows, then 1 → `almost_full` asserts after the first push. `out_data` is stable while stalled; no loss; `overflow` stays 0.
3. **Overflow:** COLS=4, ROWS=6, FIFO_DEPTH=4, `out_ready`=0 throughout → rows 5 and 6 dropped, `overflow`=1, FSM reaches DRAIN. Popping the 4 stored rows does not return to IDLE, since the last-flagged row was dropped; only reset recovers.
4. **Skew error:** column 2 of vector 0 delivered one cycle late → `skew_err`=1, that row is not pushed. A subsequent `start` after reset clears the flag.
5. **Async reset mid-COLLECT:** after 2 rows pushed, assert `reset` low → `out_valid`, `busy`, flags and FIFO clear immediately. A new tile afterwards completes normally.
6. **`PSUM_COLLECT_RELU_EN` defined:** column value 16'hFFF0 → output 0; 16'h7FFF → 16'h7FFF.
